m68k_bus_initiator: RTL
=======================

Name: m68k_bus_initiator

Overview:
- Bus master for the on-chip 68000-style slave bus (data_write/data_read, 24-bit addr, active-low uds/lds, rw, active-low ack).
- Takes single read/write commands from a simple valid/ready command port and runs one strobed bus cycle per command.
- Returns read data or an error on a response port.
- Used by loader/DMA-style engines, e.g. the UART boot loader, to reach SRAM and peripherals without the CPU.

Parameters:
- SETUP_CYCLES, 1, clocks addr/rw/data are stable with strobes high before strobes assert (1..15).
- TIMEOUT_CYCLES, 255, clocks to wait for ack low before aborting with bus error (1..65535).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  initiator accepts command this cycle
- cmd_rw  in  1  1=read, 0=write
- cmd_addr  in  24  byte address
- cmd_byte  in  1  1=byte access, 0=word access
- cmd_wdata  in  16  write data; for byte access the byte is in [7:0]
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  16  read data; byte reads zero-extended into [7:0]
- rsp_err  out  2  00=ok, 01=timeout, 10=address error (qualified by rsp_valid)
- addr  out  24  bus address
- data_write  out  16  bus write data
- data_read  in  16  bus read data
- uds  out  1  upper data strobe, active low, data[15:8], even byte
- lds  out  1  lower data strobe, active low, data[7:0], odd byte
- rw  out  1  bus direction, 1=read
- ack  in  1  slave acknowledge, active low
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, any state) sets all outputs to the following and abandons any cycle in flight:
  - IDLE; uds=lds=1; rw=1; addr=0; data_write=0
  - cmd_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=00; busy=0
- Command acceptance: a command is accepted on a clock where cmd_valid && cmd_ready. cmd_ready=1 only in IDLE. All command fields are registered on acceptance.
- Lane decode:
  - Word access: uds=lds=0 and data_write=cmd_wdata.
  - Byte access, addr[0]=0: uds only; data_write={wdata[7:0],wdata[7:0]}.
  - Byte access, addr[0]=1: lds only; same data_write replication.
- Word access at an odd address: no bus cycle, strobes stay high. The block goes to RESP with rsp_err=10, one cycle after acceptance.
- States:
  - IDLE -> SETUP on acceptance, or -> RESP on address error.
  - SETUP: drive addr, rw and data_write with strobes high for SETUP_CYCLES clocks, then -> STROBE.
  - STROBE: assert the decoded strobes and count waits.
    - On the first clock with ack=0: latch data_read and -> RELEASE.
    - For a byte read, latch only the addressed lane, shifted to [7:0], upper byte 0.
    - If the counter reaches TIMEOUT_CYCLES with ack still 1: err=01, -> RELEASE.
  - RELEASE: strobes high, addr/rw/data held. Stay until ack=1, then -> RESP.
    - After a timeout, RELEASE lasts exactly one cycle regardless of ack.
  - RESP: rsp_valid=1 for exactly one clock with rdata/err, then -> IDLE.
- rw returns to 1 and strobes stay 1 in IDLE. addr and data_write hold their last values.
- Minimum cycle, SETUP_CYCLES=1 with ack in the first strobe cycle: acceptance to rsp_valid = 4 clocks (SETUP, STROBE, RELEASE, RESP).
- A zero-wait slave whose ack follows the strobes combinationally must work. The strobes are registered, so ack is sampled no earlier than one clock after the strobes assert.
- Write responses carry rsp_rdata=0. A timed-out read also returns rsp_rdata=0.
- A new command may be presented during RESP, but it is accepted only in the following IDLE cycle. Back-to-back throughput is therefore one command per 5 clocks minimum.
- The timeout counter is 16 bits, cleared on entering STROBE, and saturates (no wrap).

Test Plan:
- Word write: addr=0x000100, wdata=0xA9A9, slave acks after 2 waits → uds=lds=0 and rw=0 in STROBE; rsp_valid after ack release; err=00.
- Byte reads: data_read=0x12AB at addr 0x000201, then at addr 0x000200 → first: lds-only strobe, rsp_rdata=0x00AB; second: uds-only strobe, rsp_rdata=0x0012.
- Odd word access: read at 0x000003 → no strobe activity; rsp_valid one cycle after acceptance; err=10.
- Timeout: TIMEOUT_CYCLES=8, ack stuck 1 → strobes low exactly 8 clocks, then high; err=01; rsp_rdata=0.
- Slow ack release: ack held low 3 clocks after the strobes deassert → rsp_valid delayed until ack=1; cmd_ready stays 0 the whole time.
- Reset mid-STROBE: assert reset asynchronously → uds=lds=1 and cmd_ready=1 immediately; no rsp_valid; the next command completes normally.

Source files
------------

// File: rtl/m68k_bus_initiator.sv
// m68k_bus_initiator
//   Bus master for the on-chip 68000-style slave bus. Accepts one read or
//   write command per valid/ready handshake, runs a single strobed bus cycle
//   (SETUP -> STROBE -> RELEASE) and returns data/status as a one-clock
//   response pulse.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   cmd_valid/cmd_ready     command handshake (ready only in IDLE)
//   cmd_rw/addr/byte/wdata  command fields, registered on acceptance
//   rsp_valid/rdata/err     response pulse; err 00 ok, 01 timeout, 10 addr
//   addr/data_write/rw      bus address, write data, direction (1=read)
//   uds/lds                 active-low byte strobes (upper=even, lower=odd)
//   data_read/ack           bus read data, active-low slave acknowledge
//   busy                    high whenever not IDLE
module m68k_bus_initiator #(
  parameter int SETUP_CYCLES   = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [23:0] cmd_addr,
  input  logic        cmd_byte,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic [23:0] addr,
  output logic [15:0] data_write,
  input  logic [15:0] data_read,
  output logic        uds,
  output logic        lds,
  output logic        rw,
  input  logic        ack,
  output logic        busy
);

  localparam logic [3:0]  SETUP_N = 4'(SETUP_CYCLES);
  // Counter value on the last strobe clock before giving up.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, RELEASE, RESP} state_t;
  state_t state, state_n;

  logic [3:0]  setup_cnt;
  logic [15:0] wait_cnt;
  logic        byte_q;
  logic        timed_out;

  logic accept, addr_err, u_en, l_en, timeout_hit;

  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign accept      = cmd_valid && cmd_ready;
  assign addr_err    = !cmd_byte && cmd_addr[0];
  // Lane decode from the registered command: words use both lanes.
  assign u_en        = !byte_q || !addr[0];
  assign l_en        = !byte_q ||  addr[0];
  assign timeout_hit = (wait_cnt >= TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = addr_err ? RESP : SETUP;
      SETUP:   if (setup_cnt >= SETUP_N) state_n = STROBE;
      STROBE:  if (!ack || timeout_hit) state_n = RELEASE;
      // After a timeout the slave may never release; leave after one clock.
      RELEASE: if (timed_out || ack) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr       <= '0;
      data_write <= '0;
      uds        <= 1'b1;
      lds        <= 1'b1;
      rw         <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 2'b00;
      setup_cnt  <= '0;
      wait_cnt   <= '0;
      byte_q     <= 1'b0;
      timed_out  <= 1'b0;
    end else begin
      rsp_valid <= (state_n == RESP);
      // Strobes come straight from flops so the bus never sees a glitch.
      uds <= !((state_n == STROBE) && u_en);
      lds <= !((state_n == STROBE) && l_en);
      if (state_n == IDLE) rw <= 1'b1;
      case (state)
        IDLE: if (accept) begin
          addr       <= cmd_addr;
          byte_q     <= cmd_byte;
          data_write <= cmd_byte ? {cmd_wdata[7:0], cmd_wdata[7:0]} : cmd_wdata;
          rw         <= addr_err ? 1'b1 : cmd_rw;
          rsp_rdata  <= '0;
          rsp_err    <= addr_err ? 2'b10 : 2'b00;
          timed_out  <= 1'b0;
          setup_cnt  <= 4'd1;
        end
        SETUP: begin
          setup_cnt <= setup_cnt + 4'd1;
          if (state_n == STROBE) wait_cnt <= '0;
        end
        STROBE: begin
          if (!ack) begin
            if (rw)
              rsp_rdata <= !byte_q ? data_read :
                           addr[0] ? {8'h00, data_read[7:0]} :
                                     {8'h00, data_read[15:8]};
          end else if (timeout_hit) begin
            rsp_err   <= 2'b01;
            timed_out <= 1'b1;
          end else if (wait_cnt != 16'hFFFF) begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
